// File: rtl/quad_sample_gather_if.sv
// Sample-in / frame-out bus for quad_sample_gather.
// The master side feeds samples and consumes frames; the slave side is the gatherer.
interface quad_sample_gather_if #(
    parameter int W = 4
);
    logic [W-1:0] DIN;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic         partial;
    logic [7:0]   frame_cnt;

    modport master (
        output DIN, in_valid, out_ready,
        input  in_ready, A, B, C, D, out_valid, partial, frame_cnt
    );

    modport slave (
        input  DIN, in_valid, out_ready,
        output in_ready, A, B, C, D, out_valid, partial, frame_cnt
    );
endinterface

// File: rtl/quad_sample_gather.sv
// quad_sample_gather: packs four consecutive W-bit samples into one frame (A..D)
// and holds it until downstream takes it. Frames taken are counted modulo 256.
// Optional feature: define GATHER_TIMEOUT_EN to flush a partly filled frame
// after TIMEOUT idle cycles. The flushed frame has its unfilled slots at 0
// and raises partial.
module quad_sample_gather #(
    parameter int W       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    quad_sample_gather_if.slave  bus
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          idx;
    logic [3:0][W-1:0]   slots;
    logic [7:0]          frame_cnt;
    logic                in_ready;
    logic                out_valid;
    logic                accept;
    logic                handshake;

`ifdef GATHER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] idle_cnt;
    logic       timeout_hit;
    logic       partial;

    // The flush fires on the idle cycle that brings the counter to TIMEOUT.
    // A sample arriving in that same cycle wins, so in_valid suppresses the flush.
    assign timeout_hit = (state == FILL) && (idx != 2'd0) && !bus.in_valid
                         && (idle_cnt == TIMEOUT_LAST);
`endif

    // State register; reset always lands in FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
`ifdef GATHER_TIMEOUT_EN
                if ((accept && (idx == 2'd3)) || timeout_hit) begin
                    state_next = FULL;
                end
`else
                if (accept && (idx == 2'd3)) begin
                    state_next = FULL;
                end
`endif
            end
            FULL: begin
                out_valid = 1'b1;
                handshake = bus.out_ready;
                if (handshake) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Slot storage, fill index and frame counter. A handshake empties the frame
    // so that unwritten slots read 0 during the next fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 2'd0;
            slots     <= '0;
            frame_cnt <= 8'd0;
        end else if (handshake) begin
            idx       <= 2'd0;
            slots     <= '0;
            frame_cnt <= frame_cnt + 8'd1;
        end else if (accept) begin
            slots[idx] <= bus.DIN;
            idx        <= idx + 2'd1;
        end
    end

`ifdef GATHER_TIMEOUT_EN
    // Idle counter only runs while a frame is partly filled and nothing arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= 8'd0;
        end else if ((state != FILL) || (idx == 2'd0) || accept || timeout_hit) begin
            idle_cnt <= 8'd0;
        end else begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    // partial marks a frame that was flushed rather than completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            partial <= 1'b0;
        end else if (handshake) begin
            partial <= 1'b0;
        end else if (timeout_hit) begin
            partial <= 1'b1;
        end
    end

    assign bus.partial = partial;
`else
    assign bus.partial = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.A         = slots[0];
    assign bus.B         = slots[1];
    assign bus.C         = slots[2];
    assign bus.D         = slots[3];
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_quad_sample_gather.sv
// Directed testbench for quad_sample_gather (W = 4, TIMEOUT = 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_quad_sample_gather;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    quad_sample_gather_if #(.W(4)) bus ();

    quad_sample_gather #(.W(4), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.DIN       = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.DIN       = 4'd5;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.partial !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got out_valid=%0b partial=%0b expected 0/0",
                     bus.out_valid, bus.partial);
        end
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 16'h0000 || bus.frame_cnt !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL reset_data: got ABCD=%h cnt=%0d expected 0000/0",
                     {bus.A, bus.B, bus.C, bus.D}, bus.frame_cnt);
        end
    endtask

    task automatic test_basic();
        logic [3:0] vals [4];
        vals = '{4'd0, 4'd3, 4'd0, 4'd0};
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.DIN = vals[i];
            if (i == 3) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL basic_early_valid: got %0b expected 0", bus.out_valid);
                end
            end
            tick();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.partial !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_full: got out_valid=%0b in_ready=%0b partial=%0b expected 1/0/0",
                     bus.out_valid, bus.in_ready, bus.partial);
        end
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 16'h0300) begin
            n_err++;
            $display("[TB] FAIL basic_frame: got ABCD=%h expected 0300", {bus.A, bus.B, bus.C, bus.D});
        end
        bus.DIN = 4'd15;
        tick();
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 16'h0300 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL basic_ignore_in_full: got ABCD=%h out_valid=%0b expected 0300/1",
                     {bus.A, bus.B, bus.C, bus.D}, bus.out_valid);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.frame_cnt !== 8'd1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_handshake: got cnt=%0d in_ready=%0b out_valid=%0b expected 1/1/0",
                     bus.frame_cnt, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_hold();
        logic [3:0] vals [4];
        vals = '{4'd10, 4'd5, 4'd2, 4'd14};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.DIN = vals[i];
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({bus.A, bus.B, bus.C, bus.D} !== 16'hA52E || bus.in_ready !== 1'b0
                || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL hold_cycle%0d: got ABCD=%h in_ready=%0b out_valid=%0b expected A52E/0/1",
                         i, {bus.A, bus.B, bus.C, bus.D}, bus.in_ready, bus.out_valid);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.frame_cnt !== 8'd2 || {bus.A, bus.B, bus.C, bus.D} !== 16'h0000
            || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL hold_release: got cnt=%0d ABCD=%h in_ready=%0b expected 2/0000/1",
                     bus.frame_cnt, {bus.A, bus.B, bus.C, bus.D}, bus.in_ready);
        end
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.frame_cnt !== 8'd2 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL hold_ready_in_fill: got cnt=%0d out_valid=%0b expected 2/0",
                     bus.frame_cnt, bus.out_valid);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.DIN      = (i % 2 == 0) ? 4'd5 : 4'd9;
            if (i == 6) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL toggle_early_valid: got %0b expected 0", bus.out_valid);
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || {bus.A, bus.B, bus.C, bus.D} !== 16'h5555) begin
            n_err++;
            $display("[TB] FAIL toggle_frame: got out_valid=%0b ABCD=%h expected 1/5555",
                     bus.out_valid, {bus.A, bus.B, bus.C, bus.D});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.frame_cnt !== 8'd3) begin
            n_err++;
            $display("[TB] FAIL toggle_count: got %0d expected 3", bus.frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        bus.in_valid = 1'b1;
        bus.DIN      = 4'd7;
        tick();
        bus.DIN = 4'd9;
        tick();
        rst     = 1'b1;
        bus.DIN = 4'd3;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.A !== 4'd0 || bus.B !== 4'd0 || bus.out_valid !== 1'b0 || bus.frame_cnt !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL midreset_state: got A=%0d B=%0d out_valid=%0b cnt=%0d expected 0/0/0/0",
                     bus.A, bus.B, bus.out_valid, bus.frame_cnt);
        end
        bus.in_valid = 1'b1;
        bus.DIN      = 4'd6;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.A !== 4'd6 || bus.B !== 4'd0) begin
            n_err++;
            $display("[TB] FAIL midreset_idx: got A=%0d B=%0d expected 6/0", bus.A, bus.B);
        end
    endtask

    task automatic test_timeout();
        logic exp_flush;
`ifdef GATHER_TIMEOUT_EN
        exp_flush = 1'b1;
`else
        exp_flush = 1'b0;
`endif
        do_reset();
        bus.in_valid = 1'b1;
        bus.DIN      = 4'd12;
        tick();
        bus.DIN = 4'd4;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL timeout_early: got out_valid=%0b expected 0", bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== exp_flush || bus.partial !== exp_flush) begin
            n_err++;
            $display("[TB] FAIL timeout_flush: got out_valid=%0b partial=%0b expected %0b/%0b",
                     bus.out_valid, bus.partial, exp_flush, exp_flush);
        end
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 16'hC400) begin
            n_err++;
            $display("[TB] FAIL timeout_frame: got ABCD=%h expected C400", {bus.A, bus.B, bus.C, bus.D});
        end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (bus.out_valid !== exp_flush || bus.partial !== exp_flush) begin
            n_err++;
            $display("[TB] FAIL timeout_later: got out_valid=%0b partial=%0b expected %0b/%0b",
                     bus.out_valid, bus.partial, exp_flush, exp_flush);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.partial !== 1'b0 || bus.frame_cnt !== {7'd0, exp_flush}) begin
            n_err++;
            $display("[TB] FAIL timeout_release: got partial=%0b cnt=%0d expected 0/%0d",
                     bus.partial, bus.frame_cnt, exp_flush);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int f = 0; f < 255; f++) begin
            for (int c = 0; c < 5; c++) begin
                bus.DIN = 4'(f + c);
                tick();
            end
        end
        n_cmp++;
        if (bus.frame_cnt !== 8'd255) begin
            n_err++;
            $display("[TB] FAIL wrap_255: got %0d expected 255", bus.frame_cnt);
        end
        for (int c = 0; c < 5; c++) tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.frame_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL wrap_256: got cnt=%0d in_ready=%0b expected 0/1",
                     bus.frame_cnt, bus.in_ready);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.DIN       = 4'd0;
        test_reset();
        test_basic();
        test_hold();
        test_toggle();
        test_reset_midframe();
        test_timeout();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
